// File: rtl/gcore_pkg.sv
// Shared definitions for the GCore multi-cycle sequencer.
// Provides opcodes, ACC source codes, FSM states and opcode classification.
package gcore_pkg;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_JUMP  = 4'b0001;
    localparam logic [3:0] OP_SAVE  = 4'b0010;
    localparam logic [3:0] OP_LOAD  = 4'b0011;
    localparam logic [3:0] OP_LOADI = 4'b0100;
    localparam logic [3:0] OP_SLL   = 4'b0101;
    localparam logic [3:0] OP_ADD   = 4'b1000;
    localparam logic [3:0] OP_SUB   = 4'b1001;
    localparam logic [3:0] OP_AND   = 4'b1010;
    localparam logic [3:0] OP_OR    = 4'b1011;
    localparam logic [3:0] OP_XOR   = 4'b1100;
    localparam logic [3:0] OP_SLT   = 4'b1110;
    localparam logic [3:0] OP_BZ    = 4'b1111;

    localparam logic [1:0] DST_MEM = 2'b00;
    localparam logic [1:0] DST_IMM = 2'b01;
    localparam logic [1:0] DST_ALU = 2'b10;
    localparam logic [1:0] DST_SLL = 2'b11;

    localparam logic [2:0] ALU_NONE = 3'b000;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_MEMRD  = 3'd3,
        S_MEMWR  = 3'd4,
        S_WB     = 3'd5
`ifdef GCORE_TIMEOUT_EN
        ,
        S_FAULT  = 3'd6
`endif
    } state_t;

    typedef enum logic [3:0] {
        C_NOP,
        C_ILL,
        C_JUMP,
        C_BZ,
        C_LOADI,
        C_SLL,
        C_LOAD,
        C_ALU,
        C_SAVE
    } op_class_t;

    function automatic op_class_t op_class(input logic [3:0] op);
        op_class_t c;
        case (op)
            OP_NOP:   c = C_NOP;
            OP_JUMP:  c = C_JUMP;
            OP_SAVE:  c = C_SAVE;
            OP_LOAD:  c = C_LOAD;
            OP_LOADI: c = C_LOADI;
            OP_SLL:   c = C_SLL;
            OP_BZ:    c = C_BZ;
            OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_XOR, OP_SLT:
                      c = C_ALU;
            default:  c = C_ILL;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gcore_mem_timeout.sv
// Memory wait watchdog: counts stalled request cycles, flags expiry.
// Used only when GCORE_TIMEOUT_EN is defined.
module gcore_mem_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req,
    input  logic ack,
    output logic expired
);

    localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);

    logic [W-1:0] cnt;
    logic         stall;

    assign stall   = req && !ack;
    assign expired = stall && (cnt == W'(TIMEOUT_CYCLES - 1));

    // An idle or completed cycle restarts the count for the next request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (stall) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

endmodule

// File: rtl/gcore_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/MEM/WB sequencer for the GCore accumulator datapath.
// Define GCORE_TIMEOUT_EN to add the memory-wait watchdog and sticky FAULT state.
module gcore_seq_ctrl
    import gcore_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run,
    input  logic [3:0] ir_op,
    input  logic       acc_zero,
    input  logic       mem_ack,
    output logic       mem_req,
    output logic       mem_we,
    output logic       mem_addr_sel,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       acc_write,
    output logic [1:0] acc_dst,
    output logic [2:0] alu_op,
    output logic       illegal_op,
    output logic       fault
);

    state_t    state;
    state_t    next;
    state_t    done_st;
    op_class_t cls;

    assign cls     = op_class(ir_op);
    assign done_st = run ? S_FETCH : S_IDLE;

`ifdef GCORE_TIMEOUT_EN
    logic to_expired;

    gcore_mem_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (mem_req),
        .ack    (mem_ack),
        .expired(to_expired)
    );
`else
    logic unused_cfg;
    assign unused_cfg = ^TIMEOUT_CYCLES;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next;
        end
    end

    always_comb begin
        next         = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_write     = 1'b0;
        mdr_write    = 1'b0;
        pc_inc       = 1'b0;
        pc_load      = 1'b0;
        acc_write    = 1'b0;
        acc_dst      = DST_MEM;
        alu_op       = ALU_NONE;
        illegal_op   = 1'b0;
        fault        = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (run) begin
                    next = S_FETCH;
                end
            end

            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_write = 1'b1;
                    pc_inc   = 1'b1;
                    next     = S_DECODE;
                end
            end

            S_DECODE: begin
                unique case (cls)
                    C_NOP: next = done_st;
                    C_ILL: begin
                        illegal_op = 1'b1;
                        next       = done_st;
                    end
                    C_JUMP: begin
                        pc_load = 1'b1;
                        next    = done_st;
                    end
                    C_BZ: begin
                        pc_load = acc_zero;
                        next    = done_st;
                    end
                    C_LOADI, C_SLL:  next = S_WB;
                    C_LOAD, C_ALU:   next = S_MEMRD;
                    C_SAVE:          next = S_MEMWR;
                    default:         next = done_st;
                endcase
            end

            S_MEMRD: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ack) begin
                    mdr_write = 1'b1;
                    next      = S_WB;
                end
            end

            S_MEMWR: begin
                mem_req      = 1'b1;
                mem_we       = 1'b1;
                mem_addr_sel = 1'b1;
                if (mem_ack) begin
                    next = done_st;
                end
            end

            S_WB: begin
                acc_write = 1'b1;
                unique case (cls)
                    C_LOADI: acc_dst = DST_IMM;
                    C_SLL:   acc_dst = DST_SLL;
                    C_ALU: begin
                        acc_dst = DST_ALU;
                        alu_op  = ir_op[2:0];
                    end
                    default: acc_dst = DST_MEM;
                endcase
                next = done_st;
            end

`ifdef GCORE_TIMEOUT_EN
            S_FAULT: begin
                fault = 1'b1;
            end
`endif

            default: next = S_IDLE;
        endcase

`ifdef GCORE_TIMEOUT_EN
        // A stalled access overrides any other transition.
        if (to_expired) begin
            next = S_FAULT;
        end
`endif
    end

endmodule

// File: tb/tb_gcore_seq_ctrl.sv
// Randomized self-checking bench for gcore_seq_ctrl.
// Expected per-cycle outputs come from an instruction-level cycle model.
module tb_gcore_seq_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       run;
    logic [3:0] ir_op;
    logic       acc_zero;
    logic       mem_ack;
    logic       mem_req;
    logic       mem_we;
    logic       mem_addr_sel;
    logic       ir_write;
    logic       mdr_write;
    logic       pc_inc;
    logic       pc_load;
    logic       acc_write;
    logic [1:0] acc_dst;
    logic [2:0] alu_op;
    logic       illegal_op;
    logic       fault;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    gcore_seq_ctrl #(
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .ir_op       (ir_op),
        .acc_zero    (acc_zero),
        .mem_ack     (mem_ack),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr_sel(mem_addr_sel),
        .ir_write    (ir_write),
        .mdr_write   (mdr_write),
        .pc_inc      (pc_inc),
        .pc_load     (pc_load),
        .acc_write   (acc_write),
        .acc_dst     (acc_dst),
        .alu_op      (alu_op),
        .illegal_op  (illegal_op),
        .fault       (fault)
    );

    typedef struct {
        logic        run;
        logic        ack;
        logic [3:0]  op;
        logic        az;
        logic [14:0] exp;
        string       tag;
    } cyc_t;

    cyc_t q[$];

    function automatic logic [14:0] obs();
        return {mem_req, mem_we, mem_addr_sel, ir_write, mdr_write,
                pc_inc, pc_load, acc_write, acc_dst, alu_op,
                illegal_op, fault};
    endfunction

    function automatic logic [14:0] pk(
        input logic req, input logic we, input logic sel,
        input logic irw, input logic mdrw, input logic pci,
        input logic pcl, input logic accw, input logic [1:0] dst,
        input logic [2:0] alu, input logic ill, input logic flt);
        return {req, we, sel, irw, mdrw, pci, pcl, accw,
                dst, alu, ill, flt};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rn();
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic push(input logic r, input logic a, input logic [3:0] o,
                        input logic z, input logic [14:0] e, input string t);
        cyc_t c;
        c.run = r; c.ack = a; c.op = o; c.az = z; c.exp = e; c.tag = t;
        q.push_back(c);
    endtask

    task automatic check(input logic [14:0] exp, input string tag);
        logic [14:0] got;
        got = obs();
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Cycle-by-cycle expectation for one instruction, starting in FETCH.
    task automatic add_instr(input logic [3:0] op, input logic az,
                             input logic run_end, input int wf,
                             input int wm, input int idl);
        bit ill  = op inside {4'h6, 4'h7, 4'hD};
        bit alu  = op inside {4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hE};
        bit rd   = alu || (op == 4'h3);
        bit wr   = (op == 4'h2);
        bit imm  = (op == 4'h4) || (op == 4'h5);
        bit pcl  = (op == 4'h1) || (op == 4'hF && az);
        bit shrt = !(rd || wr || imm);
        for (int i = 0; i < wf; i++)
            push(rb(), 1'b0, rn(), rb(),
                 pk(1,0,0,0,0,0,0,0,2'd0,3'd0,0,0), "fetch_wait");
        push(rb(), 1'b1, rn(), rb(),
             pk(1,0,0,1,0,1,0,0,2'd0,3'd0,0,0), "fetch_ack");
        push(shrt ? run_end : rb(), rb(), op, az,
             pk(0,0,0,0,0,0,pcl,0,2'd0,3'd0,ill,0), "decode");
        if (rd) begin
            for (int i = 0; i < wm; i++)
                push(rb(), 1'b0, op, rb(),
                     pk(1,0,1,0,0,0,0,0,2'd0,3'd0,0,0), "memrd_wait");
            push(rb(), 1'b1, op, rb(),
                 pk(1,0,1,0,1,0,0,0,2'd0,3'd0,0,0), "memrd_ack");
            push(run_end, rb(), op, rb(),
                 pk(0,0,0,0,0,0,0,1, alu ? 2'd2 : 2'd0,
                    alu ? op[2:0] : 3'd0, 0, 0), "wb_mem");
        end
        if (wr) begin
            for (int i = 0; i < wm; i++)
                push(rb(), 1'b0, op, rb(),
                     pk(1,1,1,0,0,0,0,0,2'd0,3'd0,0,0), "memwr_wait");
            push(run_end, 1'b1, op, rb(),
                 pk(1,1,1,0,0,0,0,0,2'd0,3'd0,0,0), "memwr_ack");
        end
        if (imm)
            push(run_end, rb(), op, rb(),
                 pk(0,0,0,0,0,0,0,1, (op == 4'h4) ? 2'd1 : 2'd3,
                    3'd0, 0, 0), "wb_imm");
        if (!run_end) begin
            for (int i = 0; i < idl; i++)
                push(1'b0, rb(), rn(), rb(), 15'd0, "idle");
            push(1'b1, rb(), rn(), rb(), 15'd0, "idle_go");
        end
    endtask

    task automatic run_q();
        cyc_t c;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(posedge clk);
            #1;
            run = c.run; mem_ack = c.ack; ir_op = c.op; acc_zero = c.az;
            @(negedge clk);
            check(c.exp, c.tag);
        end
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; ir_op = 4'h0;
        acc_zero = 1'b0; mem_ack = 1'b0;
        #3;
        check(15'd0, "reset_outputs");
        @(negedge clk);
        rst_n = 1'b1;

        push(1'b1, 1'b0, 4'h0, 1'b0, 15'd0, "idle_start");
        add_instr(4'h4, 1'b0, 1'b1, 0, 0, 0);
        add_instr(4'h8, 1'b0, 1'b1, 0, 3, 0);
        add_instr(4'hF, 1'b1, 1'b1, 1, 0, 0);
        add_instr(4'hF, 1'b0, 1'b1, 0, 0, 0);
        add_instr(4'h2, 1'b0, 1'b1, 0, 2, 0);
        add_instr(4'h6, 1'b0, 1'b0, 0, 0, 2);
        add_instr(4'h3, 1'b1, 1'b0, 2, 1, 1);
        run_q();

        for (int n = 0; n < 150; n++) begin
            add_instr(rn(), rb(), $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3), $urandom_range(0, 3),
                      $urandom_range(0, 2));
        end
        run_q();

        // Reset in the middle of a data read
        push(1'b1, 1'b1, rn(), 1'b0,
             pk(1,0,0,1,0,1,0,0,2'd0,3'd0,0,0), "fetch_ack");
        push(1'b1, 1'b0, 4'h3, 1'b0,
             pk(0,0,0,0,0,0,0,0,2'd0,3'd0,0,0), "decode_load");
        push(1'b1, 1'b0, 4'h3, 1'b0,
             pk(1,0,1,0,0,0,0,0,2'd0,3'd0,0,0), "memrd_pre_rst");
        run_q();
        #2;
        rst_n = 1'b0;
        #1;
        check(15'd0, "async_reset_drop");
        @(negedge clk);
        run = 1'b0;
        rst_n = 1'b1;
        push(1'b0, 1'b1, rn(), 1'b0, 15'd0, "post_rst_idle");
        push(1'b0, 1'b0, rn(), 1'b0, 15'd0, "post_rst_idle");
        push(1'b1, 1'b0, rn(), 1'b0, 15'd0, "post_rst_go");
        push(1'b1, 1'b0, rn(), 1'b0,
             pk(1,0,0,0,0,0,0,0,2'd0,3'd0,0,0), "post_rst_fetch");
        run_q();

`ifdef GCORE_TIMEOUT_EN
        for (int i = 0; i < 7; i++)
            push(rb(), 1'b0, rn(), rb(),
                 pk(1,0,0,0,0,0,0,0,2'd0,3'd0,0,0), "to_wait");
        for (int i = 0; i < 5; i++)
            push(rb(), rb(), rn(), rb(),
                 pk(0,0,0,0,0,0,0,0,2'd0,3'd0,0,1), "to_fault");
        run_q();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
